// File: rtl/cw_loader.sv
// Control-word loader: assembles 8-byte CWs into even/odd banks and selects
// one per transport packet start for the key-expansion stage.
module cw_loader #(
    parameter int FIX_CHECKSUM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_parity,
    input  logic        in_abort,
    output logic        in_ready,
    input  logic        pkt_start,
    input  logic [1:0]  pkt_sc,
    output logic [63:0] cw,
    output logic        cw_valid,
    output logic        even_ok,
    output logic        odd_ok,
    output logic        sc_err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] staging_q, staging_d;
    logic        parity_q, parity_d;
    logic [63:0] even_q, odd_q;
    logic        even_ok_q, odd_ok_q;
    logic [63:0] cw_q, cw_d;
    logic        cw_valid_q, cw_valid_d;
    logic        sc_err_q, sc_err_d;
    logic        commit;
    logic [63:0] fixed;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD: begin
                if (in_abort)                      state_d = IDLE;
                else if (in_valid && cnt_q == 3'd7) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q != COMMIT);
        commit   = (state_q == COMMIT);
    end

    // Byte assembly; first byte lands in the top byte
    always_comb begin
        staging_d = staging_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    staging_d[63:56] = in_byte;
                    parity_d         = in_parity;
                    cnt_d            = 3'd1;
                end
            end
            LOAD: begin
                if (in_abort) begin
                    cnt_d = 3'd0;
                end else if (in_valid) begin
                    staging_d[{3'd7 - cnt_q, 3'b000} +: 8] = in_byte;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: cnt_d = 3'd0;
        endcase
    end

    always_comb begin
        fixed = staging_q;
        if (FIX_CHECKSUM != 0) begin
            fixed[39:32] = staging_q[63:56] + staging_q[55:48] + staging_q[47:40];
            fixed[7:0]   = staging_q[31:24] + staging_q[23:16] + staging_q[15:8];
        end
    end

    // Selection; a same-cycle commit to the selected bank is forwarded
    always_comb begin
        cw_d       = cw_q;
        cw_valid_d = cw_valid_q;
        sc_err_d   = 1'b0;
        if (pkt_start) begin
            case (pkt_sc)
                2'b10: begin
                    cw_d       = (commit && !parity_q) ? fixed : even_q;
                    cw_valid_d = even_ok_q | (commit & ~parity_q);
                end
                2'b11: begin
                    cw_d       = (commit && parity_q) ? fixed : odd_q;
                    cw_valid_d = odd_ok_q | (commit & parity_q);
                end
                2'b01: begin
                    cw_valid_d = 1'b0;
                    sc_err_d   = 1'b1;
                end
                default: cw_valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 3'd0;
            staging_q  <= '0;
            parity_q   <= 1'b0;
            even_q     <= '0;
            odd_q      <= '0;
            even_ok_q  <= 1'b0;
            odd_ok_q   <= 1'b0;
            cw_q       <= '0;
            cw_valid_q <= 1'b0;
            sc_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            staging_q  <= staging_d;
            parity_q   <= parity_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
            sc_err_q   <= sc_err_d;
            if (commit) begin
                if (parity_q) begin
                    odd_q    <= fixed;
                    odd_ok_q <= 1'b1;
                end else begin
                    even_q    <= fixed;
                    even_ok_q <= 1'b1;
                end
            end
        end
    end

    assign cw       = cw_q;
    assign cw_valid = cw_valid_q;
    assign even_ok  = even_ok_q;
    assign odd_ok   = odd_ok_q;
    assign sc_err   = sc_err_q;

endmodule

// File: tb/tb_cw_loader.sv
// Directed bench for cw_loader; two instances (checksum fix on/off) share stimulus.
module tb_cw_loader;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_parity, in_abort, pkt_start;
    logic [7:0]  in_byte;
    logic [1:0]  pkt_sc;
    logic        rdy1, v1, eok1, ook1, se1;
    logic        rdy0, v0, eok0, ook0, se0;
    logic [63:0] cw1, cw0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [63:0] c1;
        logic [63:0] c0;
        logic        v;
        logic        e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cw_loader #(.FIX_CHECKSUM(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_parity(in_parity), .in_abort(in_abort), .in_ready(rdy1),
        .pkt_start(pkt_start), .pkt_sc(pkt_sc), .cw(cw1), .cw_valid(v1),
        .even_ok(eok1), .odd_ok(ook1), .sc_err(se1));

    cw_loader #(.FIX_CHECKSUM(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .in_parity(in_parity), .in_abort(in_abort), .in_ready(rdy0),
        .pkt_start(pkt_start), .pkt_sc(pkt_sc), .cw(cw0), .cw_valid(v0),
        .even_ok(eok0), .odd_ok(ook0), .sc_err(se0));

    function automatic logic [63:0] fixcw(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        r[39:32] = v[63:56] + v[55:48] + v[47:40];
        r[7:0]   = v[31:24] + v[23:16] + v[15:8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cw1"}, cw1, 64'h0);
        chk({tag, "_cw0"}, cw0, 64'h0);
        chk({tag, "_flags1"}, {59'h0, v1, eok1, ook1, se1, rdy1}, 64'h1);
        chk({tag, "_flags0"}, {59'h0, v0, eok0, ook0, se0, rdy0}, 64'h1);
    endtask

    task automatic load(input logic [63:0] v, input logic par, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_byte   = v[63-8*i -: 8];
            in_parity = par;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // raw: unfixed bank content expected; instance 1 sees its fixed form
    task automatic pkt(input string tag, input logic [1:0] sc, input logic [63:0] raw,
                       input logic v, input logic e);
        exp_t x;
        exp_t y;
        x.tag = tag; x.c1 = fixcw(raw); x.c0 = raw; x.v = v; x.e = e;
        pkt_start = 1'b1;
        pkt_sc    = sc;
        sb.push_back(x);
        tick();
        pkt_start = 1'b0;
        pkt_sc    = 2'b00;
        y = sb.pop_front();
        chk({y.tag, "_cw1"}, cw1, y.c1);
        chk({y.tag, "_cw0"}, cw0, y.c0);
        chk({y.tag, "_vld"}, {62'h0, v1, v0}, {62'h0, y.v, y.v});
        chk({y.tag, "_err"}, {62'h0, se1, se0}, {62'h0, y.e, y.e});
    endtask

    localparam logic [63:0] X   = 64'h1122334455667788;
    localparam logic [63:0] Y   = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [63:0] SEQ = 64'h0102030405060708;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h0; in_parity = 1'b0;
        in_abort = 1'b0; pkt_start = 1'b0; pkt_sc = 2'b00;
        tick(); tick();
        rst = 1'b0;
        chk_reset("reset");

        // Even load, back-to-back bytes
        load(X, 1'b0, 8);
        chk("commit_rdy", {62'h0, rdy1, rdy0}, 64'h0);
        tick();
        chk("even_ok", {60'h0, eok1, eok0, ook1, ook0}, 64'hC);
        chk("rdy_back", {62'h0, rdy1, rdy0}, 64'h3);
        chk("fix_const", fixcw(X), 64'h1122336655667732);
        pkt("sel_even", 2'b10, X, 1'b1, 1'b0);

        // Odd empty, clear, reserved
        pkt("sel_odd_empty", 2'b11, 64'h0, 1'b0, 1'b0);
        pkt("sel_even2", 2'b10, X, 1'b1, 1'b0);
        pkt("sc_clear", 2'b00, X, 1'b0, 1'b0);
        pkt("sc_rsvd", 2'b01, X, 1'b0, 1'b1);
        tick();
        chk("sc_err_pulse", {62'h0, se1, se0}, 64'h0);

        // Odd load only
        do_reset();
        load(SEQ, 1'b1, 8);
        tick();
        chk("odd_only_ok", {60'h0, eok1, eok0, ook1, ook0}, 64'h3);
        pkt("sel_odd", 2'b11, SEQ, 1'b1, 1'b0);

        // Abort after 5 bytes; abort carries a byte that must be dropped
        do_reset();
        load(64'hAABBCCDDEE000000, 1'b1, 5);
        in_abort = 1'b1; in_valid = 1'b1; in_byte = 8'hFF;
        tick();
        in_abort = 1'b0; in_valid = 1'b0;
        tick();
        chk("abort_ok", {60'h0, eok1, eok0, ook1, ook0}, 64'h0);
        load(SEQ, 1'b1, 8);
        tick();
        pkt("abort_reload", 2'b11, SEQ, 1'b1, 1'b0);

        // Mid-packet reload is held until next packet start
        load(X, 1'b0, 8);
        tick();
        pkt("sel_x", 2'b10, X, 1'b1, 1'b0);
        load(Y, 1'b0, 8);
        tick(); tick();
        chk("hold_cw1", cw1, fixcw(X));
        chk("hold_cw0", cw0, X);
        pkt("sel_y", 2'b10, Y, 1'b1, 1'b0);
        // Packet start coincident with commit forwards the new value
        load(X, 1'b0, 8);
        pkt("fwd_commit", 2'b10, X, 1'b1, 1'b0);
        chk("odd_kept", {60'h0, eok1, eok0, ook1, ook0}, 64'hF);
        pkt("odd_untouched", 2'b11, SEQ, 1'b1, 1'b0);

        // Coincident commit into an empty bank
        do_reset();
        load(Y, 1'b1, 8);
        pkt("fwd_empty", 2'b11, Y, 1'b1, 1'b0);

        // Reset mid-load
        do_reset();
        load(Y, 1'b0, 4);
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        rst = 1'b0;
        tick();
        chk_reset("rst_after");
        load(SEQ, 1'b0, 8);
        tick();
        pkt("post_rst", 2'b10, SEQ, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cw_loader.md
Name: cw_loader

Overview:
- Upstream feeder of the CSA key schedule. Receives 8-byte control words (CW) from the host/CAM interface as a byte stream into separate even and odd CW banks.
- On each transport packet start, selects the bank indicated by the packet's scrambling-control bits. Presents it as a stable 64-bit cw to the key-expansion stage.
- Decouples asynchronous key updates from packet boundaries, so a CW written mid-packet never corrupts the packet in flight.

Parameters:
FIX_CHECKSUM, 1, when 1 overwrite byte 3 with (b0+b1+b2) mod 256 and byte 7 with (b4+b5+b6) mod 256 at commit; when 0 store bytes as received

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  CW byte strobe
in_byte  input  8  CW byte; first byte received = most significant (bits 63:56)
in_parity  input  1  target bank, sampled with first byte only: 0 even, 1 odd
in_abort  input  1  discard partial CW load
in_ready  output  1  loader accepts a byte this cycle
pkt_start  input  1  one-cycle pulse at transport packet start
pkt_sc  input  2  scrambling-control bits, valid with pkt_start
cw  output  64  selected control word to key expansion
cw_valid  output  1  cw holds a loaded key and the packet is scrambled
even_ok  output  1  even bank holds a committed CW
odd_ok  output  1  odd bank holds a committed CW
sc_err  output  1  one-cycle pulse: reserved pkt_sc=01 seen

Behaviour:
- Reset values:
  - Outputs: cw=0, cw_valid=0, even_ok=0, odd_ok=0, sc_err=0, in_ready=1.
  - Internal: staging register and both banks = 0, byte counter = 0, state IDLE.
  - Reset mid-load discards the partial CW.
- FSM states: IDLE, LOAD, COMMIT. in_ready=0 only in COMMIT. A byte is accepted when in_valid & in_ready.
- IDLE:
  - Accepted byte goes to staging[63:56]; latch in_parity; counter=1; go to LOAD.
  - in_abort is ignored.
- LOAD:
  - Accepted byte goes to staging[63-8*cnt -: 8]; counter increments.
  - Accepting the byte at cnt=7 moves the FSM to COMMIT.
  - in_abort (with or without in_valid) has priority: drop the byte, clear counter, go to IDLE, leave banks untouched.
- COMMIT (exactly one cycle):
  - Apply checksum fix per FIX_CHECKSUM.
  - Write to the latched bank and set that bank's _ok flag the following cycle.
  - Return to IDLE.
  - in_valid during COMMIT is not accepted; the source holds the byte.
- Throughput: 8 accepted bytes plus 1 commit cycle, so at most one CW per 9 cycles.
- Selection, registered, 1-cycle latency after pkt_start:
  - pkt_sc=10: cw = even bank, cw_valid = even_ok.
  - pkt_sc=11: cw = odd bank, cw_valid = odd_ok.
  - pkt_sc=00 (clear): cw unchanged, cw_valid=0.
  - pkt_sc=01: cw unchanged, cw_valid=0, sc_err=1 for one cycle.
- cw and cw_valid change only on pkt_start. A bank commit between packet starts does not alter cw until the next pkt_start, even if that bank is currently selected.
- Simultaneous COMMIT and pkt_start selecting the same bank: the committed (checksum-fixed) value is forwarded, and cw_valid=1.
- An overwritten bank keeps its _ok=1. The _ok flags clear only on rst.
- Loading one bank never disturbs the other bank.

Test Plan:
- FIX_CHECKSUM=1, parity=0, bytes 11 22 33 44 55 66 77 88 back-to-back, then pkt_start sc=10 -> in_ready low 1 cycle after 8th byte; even_ok=1; next cycle after pkt_start cw=0x1122336655667732, cw_valid=1.
- FIX_CHECKSUM=0, parity=1, bytes 01..08, pkt_start sc=11 -> cw=0x0102030405060708, cw_valid=1; even_ok stays 0.
- Even loaded, odd empty; pkt_start sc=11 -> cw_valid=0. pkt_start sc=01 -> sc_err pulses once, cw_valid=0.
- 5 bytes (AA..EE) to odd, assert in_abort, then a full odd load of 01..08 (FIX=0) -> odd bank=0x0102030405060708, no AA..EE bytes present.
- Select even (cw=X), reload even with Y mid-packet -> cw stays X until next pkt_start sc=10, then becomes Y. Repeat with pkt_start coincident with COMMIT -> Y appears immediately.
- Assert rst after 4 bytes -> all outputs at reset values; next full load starts at byte 0 correctly.
